alu_timeout_param: RTL and testbench

- Parametrised successor of the 16-cycle operand-wait ALU.
- Width, command width, operand-wait timeout and multiply pipeline depth are configurable.
- Adds a RES_VALID strobe and a latched-command operand-collection FSM.
- Sits behind the alu_intf-style interface as the DUT for the next regression generation.
- Accepts operands split across cycles via INP_VALID and flags ERR on timeout or illegal command.

---
 rtl/alu_timeout_param.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_alu_timeout_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_timeout_param.sv
// alu_timeout_param: parametrised ALU that collects operands split across cycles, with operand-wait timeout and pipelined multiply
// Latency: 2 cycles from last needed operand to RES_VALID, 2+MUL_LAT for multiplies, TIMEOUT+1 from start cycle on timeout
// Backpressure: none; new commands are accepted only in IDLE, CE=0 freezes all state and defers a pending strobe
module alu_timeout_param #(
    parameter int WIDTH   = 8,
    parameter int CWIDTH  = 4,
    parameter int TIMEOUT = 16,
    parameter int MUL_LAT = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic                 MODE,
    input  logic [CWIDTH-1:0]    CMD,
    input  logic [1:0]           INP_VALID,
    input  logic [WIDTH-1:0]     OPA,
    input  logic [WIDTH-1:0]     OPB,
    input  logic                 CIN,
    output logic [2*WIDTH-1:0]   RES,
    output logic                 RES_VALID,
    output logic                 COUT,
    output logic                 OFLOW,
    output logic                 G,
    output logic                 E,
    output logic                 L,
    output logic                 ERR
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int CMAX = (TIMEOUT > MUL_LAT) ? TIMEOUT : MUL_LAT;
    localparam int CNTW = $clog2(CMAX + 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MPIPE  = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    localparam logic [WIDTH:0]     ONE_X = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_M = {{(2*WIDTH-1){1'b0}}, 1'b1};

    // Operands a command waits for, as {need_b, need_a}; unknown commands wait for both
    function automatic logic [1:0] need_of(input logic mode, input logic [CWIDTH-1:0] cmd);
        logic [1:0] n;
        n = 2'b11;
        if (mode) begin
            case (int'(cmd))
                4, 5:    n = 2'b01;
                6, 7:    n = 2'b10;
                default: n = 2'b11;
            endcase
        end else begin
            case (int'(cmd))
                6, 8, 9:   n = 2'b01;
                7, 10, 11: n = 2'b10;
                default:   n = 2'b11;
            endcase
        end
        return n;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              mode_q, mode_d, cin_q, cin_d, tmo_q, tmo_d;
    logic [CWIDTH-1:0] cmd_q, cmd_d;
    logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
    logic              have_a_q, have_a_d, have_b_q, have_b_d;
    logic [1:0]        need_in, need_q;
    logic              mul_q;

    assign need_in = need_of(MODE, CMD);
    assign need_q  = need_of(mode_q, cmd_q);
    assign mul_q   = mode_q && (int'(cmd_q) == 9 || int'(cmd_q) == 10);

    // Next-state: operand collection, wait-timeout counting, multiply pipe hold
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        cmd_d    = cmd_q;
        cin_d    = cin_q;
        tmo_d    = tmo_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        have_a_d = have_a_q;
        have_b_d = have_b_q;
        if (CE) begin
            case (state_q)
                S_IDLE: begin
                    if (INP_VALID != 2'b00) begin
                        mode_d   = MODE;
                        cmd_d    = CMD;
                        cin_d    = CIN;
                        tmo_d    = 1'b0;
                        have_a_d = INP_VALID[0];
                        have_b_d = INP_VALID[1];
                        if (INP_VALID[0]) opa_d = OPA;
                        if (INP_VALID[1]) opb_d = OPB;
                        if ((need_in & ~INP_VALID) == 2'b00) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = CNTW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    // a re-driven operand simply overwrites the latched copy
                    if (INP_VALID[0]) begin
                        opa_d    = OPA;
                        have_a_d = 1'b1;
                    end
                    if (INP_VALID[1]) begin
                        opb_d    = OPB;
                        have_b_d = 1'b1;
                    end
                    if ((need_q & ~{have_b_d, have_a_d}) == 2'b00) begin
                        state_d = S_EXEC;
                    end else if (cnt_q == CNTW'(TIMEOUT)) begin
                        state_d = S_RESULT;
                        tmo_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
                S_EXEC: begin
                    if (mul_q && (MUL_LAT > 0)) begin
                        state_d = S_MPIPE;
                        cnt_d   = CNTW'(1);
                    end else begin
                        state_d = S_RESULT;
                    end
                end
                S_MPIPE: begin
                    if (cnt_q == CNTW'(MUL_LAT)) state_d = S_RESULT;
                    else                         cnt_d   = cnt_q + CNTW'(1);
                end
                S_RESULT: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Control and operand registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            cmd_q    <= '0;
            cin_q    <= 1'b0;
            tmo_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            have_a_q <= 1'b0;
            have_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            cmd_q    <= cmd_d;
            cin_q    <= cin_d;
            tmo_q    <= tmo_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            have_a_q <= have_a_d;
            have_b_q <= have_b_d;
        end
    end

    logic [2*WIDTH-1:0] c_res, ma, mb, dbl, rot;
    logic [WIDTH:0]     ax, bx, cx, sum;
    logic [WIDTH-1:0]   lres;
    logic [SHW-1:0]     amt;
    logic               c_cout, c_oflow, c_g, c_e, c_l, c_err, rot_oor;

    assign dbl     = {opa_q, opa_q};
    assign amt     = opb_q[SHW-1:0];
    assign rot_oor = |(opb_q >> SHW);

    // Datapath on latched operands; add/sub use a WIDTH+1 result whose top bit is carry or borrow
    always_comb begin
        c_res  = '0;
        c_cout = 1'b0;
        c_oflow = 1'b0;
        c_g    = 1'b0;
        c_e    = 1'b0;
        c_l    = 1'b0;
        c_err  = 1'b0;
        sum    = '0;
        ma     = '0;
        mb     = '0;
        rot    = '0;
        lres   = '0;
        ax     = {1'b0, opa_q};
        bx     = {1'b0, opb_q};
        cx     = (WIDTH+1)'(cin_q);
        if (mode_q) begin
            case (int'(cmd_q))
                0: begin sum = ax + bx;      c_cout  = sum[WIDTH]; end
                1: begin sum = ax - bx;      c_oflow = sum[WIDTH]; end
                2: begin sum = ax + bx + cx; c_cout  = sum[WIDTH]; end
                3: begin sum = ax - bx - cx; c_oflow = sum[WIDTH]; end
                4: begin sum = ax + ONE_X;   c_cout  = sum[WIDTH]; end
                5: begin sum = ax - ONE_X;   c_oflow = sum[WIDTH]; end
                6: begin sum = bx + ONE_X;   c_cout  = sum[WIDTH]; end
                7: begin sum = bx - ONE_X;   c_oflow = sum[WIDTH]; end
                8: begin
                    c_g = (opa_q > opb_q);
                    c_e = (opa_q == opb_q);
                    c_l = (opa_q < opb_q);
                end
                9: begin
                    ma = (2*WIDTH)'(opa_q) + ONE_M;
                    mb = (2*WIDTH)'(opb_q) + ONE_M;
                end
                10: begin
                    ma = (2*WIDTH)'({opa_q[WIDTH-2:0], 1'b0});
                    mb = (2*WIDTH)'(opb_q);
                end
                default: c_err = 1'b1;
            endcase
            if (mul_q) c_res = ma * mb;
            else       c_res = (2*WIDTH)'(sum);
        end else begin
            case (int'(cmd_q))
                0:  lres = opa_q & opb_q;
                1:  lres = ~(opa_q & opb_q);
                2:  lres = opa_q | opb_q;
                3:  lres = ~(opa_q | opb_q);
                4:  lres = opa_q ^ opb_q;
                5:  lres = ~(opa_q ^ opb_q);
                6:  lres = ~opa_q;
                7:  lres = ~opb_q;
                8:  lres = opa_q >> 1;
                9:  lres = opa_q << 1;
                10: lres = opb_q >> 1;
                11: lres = opb_q << 1;
                12: begin
                    rot   = dbl << amt;
                    lres  = rot[2*WIDTH-1:WIDTH];
                    c_err = rot_oor;
                end
                13: begin
                    rot   = dbl >> amt;
                    lres  = rot[WIDTH-1:0];
                    c_err = rot_oor;
                end
                default: c_err = 1'b1;
            endcase
            c_res = (2*WIDTH)'(lres);
        end
    end

    logic [2*WIDTH-1:0] calc_res_q, res_q;
    logic [5:0]         calc_flg_q, flg_q;
    logic               res_vld_q;

    // Capture the computed result in EXEC, publish it with a one-cycle strobe in RESULT
    always_ff @(posedge CLK) begin
        if (RST) begin
            calc_res_q <= '0;
            calc_flg_q <= '0;
            res_q      <= '0;
            flg_q      <= '0;
            res_vld_q  <= 1'b0;
        end else begin
            res_vld_q <= CE && (state_q == S_RESULT);
            if (CE && state_q == S_EXEC) begin
                calc_res_q <= c_res;
                calc_flg_q <= {c_cout, c_oflow, c_g, c_e, c_l, c_err};
            end
            if (CE && state_q == S_RESULT) begin
                if (tmo_q) begin
                    res_q <= '0;
                    flg_q <= 6'b000001;
                end else begin
                    res_q <= calc_res_q;
                    flg_q <= calc_flg_q;
                end
            end
        end
    end

    assign RES       = res_q;
    assign RES_VALID = res_vld_q;
    assign {COUT, OFLOW, G, E, L, ERR} = flg_q;

endmodule

// File: tb/tb_alu_timeout_param.sv
// tb_alu_timeout_param: randomized and directed stimulus against an arithmetic reference model, scoreboard-checked
// Latency: expected strobe cycle is carried with each scoreboard entry and compared on every RES_VALID
// Backpressure: CE stalls are injected after the last operand; each stall cycle defers the strobe by one
module tb_alu_timeout_param;
    localparam int W  = 8;
    localparam int CW = 4;
    localparam int TO = 16;
    localparam int ML = 2;

    logic            CLK = 1'b0;
    logic            RST, CE, MODE, CIN;
    logic [CW-1:0]   CMD;
    logic [1:0]      INP_VALID;
    logic [W-1:0]    OPA, OPB;
    logic [2*W-1:0]  RES;
    logic            RES_VALID, COUT, OFLOW, G, E, L, ERR;

    typedef struct {
        logic [2*W-1:0] res;
        logic [5:0]     flags;
        int             edge_n;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   tests = 0, fails = 0, cyc = 0, strobes = 0;

    alu_timeout_param #(.WIDTH(W), .CWIDTH(CW), .TIMEOUT(TO), .MUL_LAT(ML)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD), .INP_VALID(INP_VALID),
        .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .RES_VALID(RES_VALID),
        .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Which operands a command waits for: bit0 = A, bit1 = B
    function automatic int needs(input bit mode, input int cmd);
        if (mode) return (cmd == 4 || cmd == 5) ? 1 : (cmd == 6 || cmd == 7) ? 2 : 3;
        return (cmd == 6 || cmd == 8 || cmd == 9) ? 1 : (cmd == 7 || cmd == 10 || cmd == 11) ? 2 : 3;
    endfunction

    // Reference model in plain integer arithmetic
    function automatic exp_t model(input bit mode, input int cmd, input int a, input int b, input int cin);
        exp_t x;
        int M = 1 << W;
        int r = 0, amt;
        bit co = 0, of = 0, g = 0, e = 0, l = 0, er = 0;
        if (mode) begin
            case (cmd)
                0: begin r = a + b;       co = (r >= M); end
                1: begin r = a - b;       of = (r < 0); end
                2: begin r = a + b + cin; co = (r >= M); end
                3: begin r = a - b - cin; of = (r < 0); end
                4: begin r = a + 1;       co = (r >= M); end
                5: begin r = a - 1;       of = (r < 0); end
                6: begin r = b + 1;       co = (r >= M); end
                7: begin r = b - 1;       of = (r < 0); end
                8: begin g = (a > b); e = (a == b); l = (a < b); end
                9: r = ((a + 1) * (b + 1)) % (M * M);
                10: r = ((a * 2) % M) * b;
                default: er = 1;
            endcase
            if (r < 0) r = r + 2 * M;
        end else begin
            amt = b % W;
            case (cmd)
                0: r = a & b;
                1: r = M - 1 - (a & b);
                2: r = a | b;
                3: r = M - 1 - (a | b);
                4: r = a ^ b;
                5: r = M - 1 - (a ^ b);
                6: r = M - 1 - a;
                7: r = M - 1 - b;
                8: r = a / 2;
                9: r = (a * 2) % M;
                10: r = b / 2;
                11: r = (b * 2) % M;
                12: begin r = ((a * (1 << amt)) % M) + (a * (1 << amt)) / M; er = (b >= W); end
                13: begin r = a / (1 << amt) + (a % (1 << amt)) * (M / (1 << amt)); er = (b >= W); end
                default: er = 1;
            endcase
        end
        x.res    = (2*W)'(r);
        x.flags  = {co, of, g, e, l, er};
        x.edge_n = 0;
        return x;
    endfunction

    task automatic junk();
        MODE = 1'($urandom_range(0, 1));
        CMD  = CW'($urandom_range(0, 15));
        OPA  = W'($urandom);
        OPB  = W'($urandom);
    endtask

    // style 0: both operands together, 1: split A then B after gap idle cycles, 2: wrong operand only (timeout)
    task automatic run_txn(input bit mode, input int cmd, input int a, input int b, input int cin,
                           input int style, input int gap, input int stall);
        exp_t x;
        int need, drv, last_e, lat, n;
        need = needs(mode, cmd);
        x    = model(mode, cmd, a, b, cin);
        lat  = (mode && (cmd == 9 || cmd == 10)) ? 2 + ML : 2;
        @(negedge CLK);
        MODE = mode; CMD = CW'(cmd); OPA = W'(a); OPB = W'(b); CIN = 1'(cin);
        if (style == 2) begin
            drv       = (need == 3) ? 1 : 3 - need;
            INP_VALID = drv[1:0];
            lat       = TO + 1;
            x.res     = '0;
            x.flags   = 6'b000001;
        end else if (style == 1 && need == 3) begin
            INP_VALID = 2'b01;
            repeat (gap) begin
                @(negedge CLK);
                INP_VALID = 2'b00;
                junk();
            end
            @(negedge CLK);
            junk();
            OPB = W'(b);
            INP_VALID = 2'b10;
        end else begin
            drv       = (style == 1) ? need : 3;
            INP_VALID = drv[1:0];
        end
        last_e   = cyc + 1;
        x.edge_n = last_e + lat + stall;
        sb.push_back(x);
        @(negedge CLK);
        INP_VALID = 2'b00;
        if (stall > 0) begin
            CE = 1'b0;
            repeat (stall) @(negedge CLK);
            CE = 1'b1;
        end
        n = 0;
        while (sb.size() != 0 && n < TO + 40) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            chk("strobe_missing", sb.size(), 0);
            sb.delete();
        end else begin
            @(negedge CLK);
            chk("hold_res", RES, x.res);
            chk("hold_flags", {COUT, OFLOW, G, E, L, ERR}, x.flags);
            chk("strobe_len", RES_VALID, 0);
        end
    endtask

    // Monitor: every strobe must match the oldest scoreboard entry, including its cycle
    always @(negedge CLK) begin
        if (RES_VALID === 1'b1) begin
            strobes++;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", sb.size(), 1);
            end else begin
                mx = sb.pop_front();
                chk("res", RES, mx.res);
                chk("flags", {COUT, OFLOW, G, E, L, ERR}, mx.flags);
                chk("strobe_cycle", cyc, mx.edge_n);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, mode, cmd, a, b, cin, r, style, gap, stall;
        RST = 1'b1; CE = 1'b1; MODE = 1'b0; CMD = '0; INP_VALID = 2'b00;
        OPA = '0; OPB = '0; CIN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_res", RES, 0);
        chk("reset_valid", RES_VALID, 0);
        chk("reset_flags", {COUT, OFLOW, G, E, L, ERR}, 0);
        RST = 1'b0;

        run_txn(1, 0, 'hFF, 'h01, 0, 0, 0, 0);
        run_txn(1, 1, 'h05, 'h07, 0, 1, 4, 0);
        run_txn(1, 0, 'h03, 'h09, 0, 2, 0, 0);
        run_txn(1, 9, 'h0F, 'h0F, 0, 0, 0, 0);
        run_txn(1, 9, 'h0F, 'h0F, 0, 0, 0, 3);
        run_txn(1, 8, 'h3C, 'h3C, 0, 0, 0, 0);
        run_txn(0, 15, 'h12, 'h34, 0, 0, 0, 0);
        run_txn(0, 12, 'h81, 'h11, 0, 0, 0, 0);
        run_txn(1, 2, 'hFF, 'h00, 1, 1, 0, 1);
        run_txn(1, 5, 'h00, 'h00, 0, 1, 0, 0);

        // Reset while waiting for B with the wait counter at 10
        @(negedge CLK);
        s0 = strobes;
        MODE = 1'b1; CMD = '0; OPA = 8'h11; INP_VALID = 2'b01;
        @(negedge CLK);
        INP_VALID = 2'b00;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_wait_res", RES, 0);
        chk("rst_wait_valid", RES_VALID, 0);
        chk("rst_wait_flags", {COUT, OFLOW, G, E, L, ERR}, 0);
        repeat (TO + 10) @(negedge CLK);
        chk("rst_no_strobe", strobes - s0, 0);

        for (int i = 0; i < 250; i++) begin
            mode = $urandom_range(0, 1);
            cmd  = $urandom_range(0, 15);
            a    = $urandom_range(0, 255);
            b    = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 255);
            cin  = $urandom_range(0, 1);
            r    = $urandom_range(0, 9);
            style = (r == 0) ? 2 : (r < 5) ? 1 : 0;
            gap   = $urandom_range(0, TO - 2);
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_txn(mode[0], cmd, a, b, cin, style, gap, stall);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
